// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
// Shared definitions for the register-file dump block:
//   - RF geometry constants (also used where the RF itself is instantiated)
//   - dump FSM state encoding
package reg_dump_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 8;

  // IDLE: waiting for start
  // SCAN: walking addresses, one capture per accepted/empty output slot
  // LAST: final beat is held, waiting for it to be accepted
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_LAST = 2'd2
  } state_e;

endpackage

// File: rtl/reg_dump_if.sv
// reg_dump_if
// Output stream of the register-file dump.
//   out_valid : beat present on out_data/out_addr/out_last
//   out_ready : consumer can take the beat
//   out_data  : RF contents
//   out_addr  : RF index of out_data
//   out_last  : beat belongs to the highest RF address
//
// Handshake: a beat transfers at a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid is raised, the producer holds it and
// all payload fields stable until that transfer (only abort or reset may
// withdraw it). out_ready may change freely and does not depend on out_valid.
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/reg_dump_out_reg.sv
// dump_out_reg
// Single-entry valid/ready holding register for one dump beat.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : capture data_i/addr_i/last_i (only meaningful when can_load_o)
//   flush_i      : drop any held beat (takes priority over load and drain)
//   data_i       : beat payload
//   addr_i       : beat address
//   last_i       : beat is the final one
//   ready_i      : downstream ready
//   can_load_o   : slot is empty or is being emptied this cycle
//   valid_o      : beat held
//   data_o       : held payload
//   addr_o       : held address
//   last_o       : held last flag
module dump_out_reg #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              can_load_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;

  always_comb begin
    can_load_o = !valid_q || ready_i;
  end

  // Priority: flush, then load, then drain on handshake, else hold.
  // Data and address are not cleared on drain; only valid/last drop.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    if (flush_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (load_i && can_load_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
      addr_d  = addr_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;

endmodule

// File: rtl/reg_dump.sv
// reg_dump
// Sequential reader for the register file. On start it walks every RF
// address 0 .. 2**addr_w-1 through a combinational read port and streams
// each word out with its address and a last flag. Never writes the RF.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : request a dump (sampled only in IDLE)
//   abort      : cancel a dump in progress, no done pulse
//   rf_addr_o  : RF read address (the scan pointer)
//   rf_data_i  : RF read data, combinational from rf_addr_o
//   out_if     : output beat stream (master side)
//   busy       : dump in progress (SCAN or LAST)
//   done       : one-cycle pulse after the last beat is accepted
//   state_o    : current FSM state, for observation
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int addr_w = RF_ADDR_W,
  parameter int data_w = RF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [addr_w-1:0] rf_addr_o,
  input  logic [data_w-1:0] rf_data_i,
  reg_dump_if.master        out_if,
  output logic              busy,
  output logic              done,
  output state_e            state_o
);

  localparam logic [addr_w-1:0] PTR_MAX = '1;

  state_e            state_q, state_d;
  logic [addr_w-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  logic              can_load;
  logic              capture;
  logic              flush;
  logic              last_accept;
  logic              ptr_at_max;
  logic              out_valid;
  logic [data_w-1:0] out_data;
  logic [addr_w-1:0] out_addr;
  logic              out_last;

  assign ptr_at_max = (ptr_q == PTR_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. abort outranks the capture/handshake in SCAN and LAST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: begin
        if (abort)                        state_d = ST_IDLE;
        else if (can_load && ptr_at_max)  state_d = ST_LAST;
      end
      ST_LAST: begin
        if (abort)                         state_d = ST_IDLE;
        else if (out_valid && out_if.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    busy        = (state_q != ST_IDLE);
    capture     = (state_q == ST_SCAN) && can_load && !abort;
    flush       = busy && abort;
    last_accept = (state_q == ST_LAST) && out_valid && out_if.out_ready && !abort;
    done_d      = last_accept;
    ptr_d       = ptr_q;
    case (state_q)
      ST_IDLE: ptr_d = '0;
      ST_SCAN: begin
        if (abort)                     ptr_d = '0;
        // At the top address the pointer parks until LAST completes.
        else if (capture && !ptr_at_max) ptr_d = ptr_q + 1'b1;
      end
      ST_LAST: if (abort || last_accept) ptr_d = '0;
      default: ptr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      done_q <= done_d;
    end
  end

  dump_out_reg #(
    .ADDR_W (addr_w),
    .DATA_W (data_w)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (capture),
    .flush_i    (flush),
    .data_i     (rf_data_i),
    .addr_i     (ptr_q),
    .last_i     (ptr_at_max),
    .ready_i    (out_if.out_ready),
    .can_load_o (can_load),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .addr_o     (out_addr),
    .last_o     (out_last)
  );

  assign out_if.out_valid = out_valid;
  assign out_if.out_data  = out_data;
  assign out_if.out_addr  = out_addr;
  assign out_if.out_last  = out_last;

  assign rf_addr_o = ptr_q;
  assign done      = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump
// Directed bench for reg_dump. Drivers change inputs 1 time unit after the
// rising edge; a monitor on the falling edge pops expected beats from a
// queue whenever a handshake is about to happen and compares them.
module tb_reg_dump;
  import reg_dump_pkg::*;

  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;
  localparam int N  = 1 << AW;
  localparam int BW = AW + DW + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] rf_addr_o;
  logic [DW-1:0] rf_data_i;
  logic          busy;
  logic          done;
  state_e        state_o;
  logic [DW-1:0] rf [N];

  always #5 clk = ~clk;

  reg_dump_if #(.ADDR_W(AW), .DATA_W(DW)) out_if ();

  assign rf_data_i = rf[rf_addr_o];

  reg_dump #(.addr_w(AW), .data_w(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .rf_addr_o (rf_addr_o),
    .rf_data_i (rf_data_i),
    .out_if    (out_if),
    .busy      (busy),
    .done      (done),
    .state_o   (state_o)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail = 0;
  int            beats_seen = 0;
  int            done_cnt = 0;
  logic [BW-1:0] exp_q[$];
  logic          drop_ok = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(int ovr_idx, logic [DW-1:0] ovr_val);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      a = AW'(i);
      d = (i == ovr_idx) ? ovr_val : rf[i];
      exp_q.push_back({a, d, (i == N - 1)});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beat(string name, int addr);
    int k = 0;
    while (!(out_if.out_valid && out_if.out_addr == AW'(addr)) && k < 60) begin
      tick();
      k++;
    end
    chk(name, {31'd0, out_if.out_valid}, 32'd1);
  endtask

  task automatic wait_done(string name, int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  // ---------------- monitor ----------------
  logic          prev_stall = 1'b0;
  logic          prev_last_hs = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  logic [BW-1:0] cur_beat;
  logic [BW-1:0] exp_beat;

  always @(negedge clk) begin
    cur_beat = {out_if.out_addr, out_if.out_data, out_if.out_last};
    if (!reset) begin
      chk("done_timing", {31'd0, done}, {31'd0, prev_last_hs});
      if (prev_stall && !drop_ok) begin
        chk("stall_valid", {31'd0, out_if.out_valid}, 32'd1);
        chk("stall_hold", 32'(cur_beat), 32'(prev_beat));
      end
    end
    if (done) done_cnt++;
    if (out_if.out_valid && out_if.out_ready && !reset) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(cur_beat), 32'hFFFF_FFFF);
      end else begin
        exp_beat = exp_q.pop_front();
        chk("beat", 32'(cur_beat), 32'(exp_beat));
      end
    end
    prev_stall   = out_if.out_valid && !out_if.out_ready;
    prev_last_hs = out_if.out_valid && out_if.out_ready && out_if.out_last && !abort && !reset;
    prev_beat    = cur_beat;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int b0;
  int d0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_if.out_ready = 1'b0;
    for (int i = 0; i < N; i++) rf[i] = 8'(8'hA0 + i);

    tick();
    tick();
    chk("rst_valid", {31'd0, out_if.out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_if.out_data}, 32'd0);
    chk("rst_addr", {28'd0, out_if.out_addr}, 32'd0);
    chk("rst_last", {31'd0, out_if.out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rf_addr", {28'd0, rf_addr_o}, 32'd0);
    reset = 1'b0;
    tick();

    // Test 1: full-throughput dump, exact cycle timing
    out_if.out_ready = 1'b1;
    push_dump(-1, 8'h00);
    b0 = beats_seen;
    d0 = done_cnt;
    pulse_start();                                  // edge N
    chk("t1_busy_n", {31'd0, busy}, 32'd1);
    chk("t1_valid_n", {31'd0, out_if.out_valid}, 32'd0);
    tick();                                         // edge N+1
    chk("t1_beat0_valid", {31'd0, out_if.out_valid}, 32'd1);
    chk("t1_beat0_addr", {28'd0, out_if.out_addr}, 32'd0);
    chk("t1_beat0_data", {24'd0, out_if.out_data}, 32'hA0);
    chk("t1_beat0_last", {31'd0, out_if.out_last}, 32'd0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      chk("t1_busy", {31'd0, busy}, 32'd1);
    end
    chk("t1_beat15_addr", {28'd0, out_if.out_addr}, 32'd15);
    chk("t1_beat15_data", {24'd0, out_if.out_data}, 32'hAF);
    chk("t1_beat15_last", {31'd0, out_if.out_last}, 32'd1);
    tick();                                         // edge N+17
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_valid_end", {31'd0, out_if.out_valid}, 32'd0);
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_beats", 32'(beats_seen - b0), 32'd16);
    chk("t1_dones", 32'(done_cnt - d0), 32'd1);

    // Test 2: back-pressure pattern 1,0,0,...
    push_dump(-1, 8'h00);
    b0 = beats_seen;
    d0 = done_cnt;
    pulse_start();
    begin
      int k = 0;
      while (!done && k < 200) begin
        out_if.out_ready = (k % 3 == 0);
        tick();
        k++;
      end
    end
    chk("t2_done", {31'd0, done}, 32'd1);
    out_if.out_ready = 1'b1;
    tick();
    chk("t2_beats", 32'(beats_seen - b0), 32'd16);
    chk("t2_dones", 32'(done_cnt - d0), 32'd1);
    chk("t2_queue", 32'(exp_q.size()), 32'd0);

    // Test 3: abort while beat 5 is stalled, then a fresh dump
    out_if.out_ready = 1'b1;
    push_dump(-1, 8'h00);
    pulse_start();
    wait_beat("t3_reach5", 5);
    out_if.out_ready = 1'b0;
    tick();
    chk("t3_stall_addr", {28'd0, out_if.out_addr}, 32'd5);
    drop_ok = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_valid", {31'd0, out_if.out_valid}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_rf_addr", {28'd0, rf_addr_o}, 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    tick();
    chk("t3_no_done", {31'd0, done}, 32'd0);
    drop_ok = 1'b0;
    tick();
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd0);
    out_if.out_ready = 1'b1;
    push_dump(-1, 8'h00);
    b0 = beats_seen;
    pulse_start();
    tick();
    chk("t3_restart_addr", {28'd0, out_if.out_addr}, 32'd0);
    chk("t3_restart_valid", {31'd0, out_if.out_valid}, 32'd1);
    wait_done("t3_restart_done", 40);
    tick();
    chk("t3_restart_beats", 32'(beats_seen - b0), 32'd16);

    // Test 4: reset at beat 9 with start in the same cycle
    out_if.out_ready = 1'b1;
    push_dump(-1, 8'h00);
    pulse_start();
    wait_beat("t4_reach9", 9);
    out_if.out_ready = 1'b0;
    drop_ok = 1'b1;
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("t4_valid", {31'd0, out_if.out_valid}, 32'd0);
    chk("t4_data", {24'd0, out_if.out_data}, 32'd0);
    chk("t4_addr", {28'd0, out_if.out_addr}, 32'd0);
    chk("t4_last", {31'd0, out_if.out_last}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    tick();
    chk("t4_start_ignored", {31'd0, busy}, 32'd0);
    drop_ok = 1'b0;
    out_if.out_ready = 1'b1;
    tick();

    // Test 5: start re-pulsed mid-dump is ignored
    push_dump(-1, 8'h00);
    b0 = beats_seen;
    d0 = done_cnt;
    pulse_start();
    wait_beat("t5_reach3", 3);
    pulse_start();
    wait_done("t5_done", 40);
    tick();
    tick();
    tick();
    chk("t5_beats", 32'(beats_seen - b0), 32'd16);
    chk("t5_dones", 32'(done_cnt - d0), 32'd1);
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // Test 6: RF write lands before address 12 is read
    push_dump(12, 8'h5C);
    b0 = beats_seen;
    pulse_start();
    wait_beat("t6_reach4", 4);
    tick();                                         // beat 4 accepted here
    rf[12] = 8'h5C;
    wait_done("t6_done", 40);
    tick();
    chk("t6_beats", 32'(beats_seen - b0), 32'd16);
    rf[12] = 8'hAC;

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
Name: reg_dump

Overview:
Sequential reader for the register file. On `start` it walks every RF address from 0 to 2**addr_w-1 through one combinational read port and streams each value out on a valid/ready interface, tagged with its address and a last flag. It sits beside the datapath and drives a spare RF read port, for debug dump, end-of-program result extraction and bench checking. It never writes the RF.

Parameters:
addr_w, 4, RF address width; the block scans 2**addr_w entries (16 by default)
data_w, 8, RF word width; must match the RF (8)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a dump; sampled only in IDLE
abort  input  1  synchronous cancel of a dump in progress
rf_addr_o  output  addr_w  read address to the RF read port
rf_data_i  input  data_w  RF read data, combinational from rf_addr_o in the same cycle
out_valid  output  1  out_data, out_addr and out_last hold a beat
out_ready  input  1  consumer accepts the beat when out_valid & out_ready at a rising edge
out_data  output  data_w  RF contents
out_addr  output  addr_w  RF index of out_data
out_last  output  1  beat is for address 2**addr_w-1
busy  output  1  high in SCAN and LAST
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (sync, high): state=IDLE, ptr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0. Reset wins over start, abort and a handshake in the same cycle.
- rf_addr_o = ptr at all times. It is 0 in IDLE.
- FSM states: IDLE, SCAN, LAST.
- IDLE: start=1 at edge N -> SCAN, ptr=0.
- SCAN capture condition: out_valid==0 or out_ready==1. At the edge where capture holds:
  - out_data<=rf_data_i, out_addr<=ptr, out_valid<=1, out_last<=(ptr==max).
  - ptr<=ptr+1.
  - If ptr==max: go to LAST instead and hold ptr at max (no wrap).
- SCAN stall: if out_valid=1 and out_ready=0, all outputs and ptr hold. Data must stay stable while stalled.
- LAST: waits for the final beat to be accepted. At that edge: out_valid<=0, out_last<=0, done<=1, state->IDLE, ptr<=0.
- done is high for exactly one cycle, then returns to 0.
- Timing with out_ready held at 1 and start at edge N:
  - beat 0 becomes valid after edge N+1.
  - beat k is accepted at edge N+2+k.
  - with 16 entries, the last beat is accepted at N+17 and done is high in the cycle after N+17.
  - Throughput is 1 beat per cycle.
- start while busy: ignored. No queuing, no restart.
- start in the same cycle as the done edge: ignored, because the state is not yet IDLE. A new dump needs start in a later cycle.
- abort=1 in SCAN or LAST: next edge -> IDLE, out_valid=0, ptr=0, no done pulse. Any pending beat is dropped even if out_ready=1 in that cycle.
- abort in IDLE: no effect.
- Coherency: RF writes during a scan are visible if they land before that address is captured. There is no snapshot; the caller stalls the core if it needs a coherent dump.
- out_valid never drops without a handshake, except on abort or reset.

Decomposition:
- Shared package holds the state enum type (IDLE/SCAN/LAST) and the RF geometry constants. RF_ADDR_W=4 and RF_DATA_W=8 are also used by the RF instantiation.
- One natural sub-module: dump_out_reg, a single-entry valid/ready holding register for data, addr and last with the load/hold rule above. The FSM and pointer stay in the top.

Test Plan:
- Preload RF[i]=8'hA0+i; start pulse; out_ready=1 -> 16 beats on consecutive cycles with (addr i, data A0+i). out_last only on addr 15 with data AF. done one cycle after beat 15. busy high from N+1 through N+17.
- Same preload; out_ready toggles 1,0,0,1,... -> every beat delivered exactly once in order. out_data is stable across stall cycles. Total beats = 16.
- Assert abort while beat addr 5 is valid and out_ready=0 -> out_valid=0 next cycle, no done, busy=0. A new start then yields beats from addr 0.
- Assert reset at beat addr 9 -> all outputs return to 0 at the next edge. start asserted in the same cycle is ignored.
- Pulse start again at beat addr 3 -> no effect: exactly 16 beats and one done.
- Write RF[12]=8'h5C at the edge where beat addr 4 is accepted -> beat addr 12 carries 8'h5C.
